// File: rtl/video_enhance_auto_if.sv
// ---------------------------------------------------------------------------
// video_enhance_auto_if
// Video stream bundle for the enhancement path: input syncs/DE/pixel
// and the delayed output syncs/DE/pixel.
//   master : the side that drives vs_in/hs_in/de_in/r_in/g_in/b_in
//   slave  : the enhancement block, drives vs_out/hs_out/de_out/r_out/g_out/b_out
// ---------------------------------------------------------------------------
interface video_enhance_auto_if #(
    parameter int DW = 8
) ();
    logic          vs_in;
    logic          hs_in;
    logic          de_in;
    logic [DW-1:0] r_in;
    logic [DW-1:0] g_in;
    logic [DW-1:0] b_in;
    logic          vs_out;
    logic          hs_out;
    logic          de_out;
    logic [DW-1:0] r_out;
    logic [DW-1:0] g_out;
    logic [DW-1:0] b_out;

    modport master (
        output vs_in, hs_in, de_in, r_in, g_in, b_in,
        input  vs_out, hs_out, de_out, r_out, g_out, b_out
    );

    modport slave (
        input  vs_in, hs_in, de_in, r_in, g_in, b_in,
        output vs_out, hs_out, de_out, r_out, g_out, b_out
    );
endinterface

// File: rtl/video_enhance_auto.sv
// ---------------------------------------------------------------------------
// video_enhance_auto
// RGB -> YUV, luma offset (bypass / manual / automatic per-frame brightness
// correction), YUV -> RGB. Syncs and DE are delayed to match the datapath.
// Ports:
//   pix_clk, rst        : pixel clock, synchronous active-high reset
//   vid (slave)         : input syncs/DE/RGB, output syncs/DE/RGB (LAT later)
//   mode                : 0/3 bypass, 1 manual offset, 2 auto; latched per frame
//   manual_offset       : signed luma offset used in manual mode
//   auto_target         : desired frame mean luma
//   auto_step           : max change of the offset per frame
//   frame_mean          : mean pre-adjust luma of the last full frame
//   cur_offset          : signed offset currently applied
//   stats_valid         : last frame delivered 2^SAMPLE_LOG samples
// Datapath stages: products/sums, shift (Y/U/V), adjust, inverse products,
// inverse shift, add+clamp, output mask -> 7 cycles.
// ---------------------------------------------------------------------------
module video_enhance_auto #(
    parameter int DW         = 8,
    parameter int SAMPLE_LOG = 16,
    parameter int VS_POL     = 1,
    parameter int LAT        = 7   // sync delay depth; matches the 7-stage datapath
) (
    input  logic                  pix_clk,
    input  logic                  rst,
    video_enhance_auto_if.slave   vid,
    input  logic [1:0]            mode,
    input  logic signed [DW:0]    manual_offset,
    input  logic [DW-1:0]         auto_target,
    input  logic [DW-1:0]         auto_step,
    output logic [DW-1:0]         frame_mean,
    output logic signed [DW:0]    cur_offset,
    output logic                  stats_valid
);
    localparam int PW = DW + 10;            // product width, covers 454 * 2^(DW-1) with sign
    localparam int EW = DW + 3;             // offset arithmetic width
    localparam int AW = SAMPLE_LOG + DW;    // accumulator width
    localparam int CW = SAMPLE_LOG + 1;     // sample counter width
    localparam logic [DW-1:0]        H    = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV = PW'((1 << DW) - 1);
    localparam logic signed [EW-1:0] LIM  = EW'((1 << DW) - 1);
    localparam logic signed [PW-1:0] K21  = PW'(21),  K29  = PW'(29),  K43  = PW'(43);
    localparam logic signed [PW-1:0] K77  = PW'(77),  K85  = PW'(85),  K88  = PW'(88);
    localparam logic signed [PW-1:0] K107 = PW'(107), K128 = PW'(128), K150 = PW'(150);
    localparam logic signed [PW-1:0] K183 = PW'(183), K359 = PW'(359), K454 = PW'(454);

    typedef enum logic [1:0] {
        MODE_BYP  = 2'd0,
        MODE_MAN  = 2'd1,
        MODE_AUTO = 2'd2,
        MODE_BYP3 = 2'd3
    } mode_e;

    function automatic logic [DW-1:0] clamp_pw(input logic signed [PW-1:0] x);
        if (x[PW-1])
            return '0;
        else if (x > MAXV)
            return '1;
        else
            return x[DW-1:0];
    endfunction

    // ---------------- sync / DE delay line (3 bits per stage) ----------------
    logic [3*LAT-1:0] sync_q;

    // ---------------- datapath registers ----------------
    logic signed [PW-1:0] y_sum_q, u_sum_q, v_sum_q;       // stage 1
    logic [DW-1:0]        y_q, u_q, v_q;                   // stage 2 (pre-adjust YUV)
    logic [DW-1:0]        ya_q, ua_q, va_q;                // stage 3 (adjusted)
    logic [DW-1:0]        yb_q;                            // stage 4
    logic signed [PW-1:0] pr_q, pg_q, pb_q;
    logic [DW-1:0]        yc_q;                            // stage 5
    logic signed [PW-1:0] rt_q, gt_q, bt_q;
    logic [DW-1:0]        r6_q, g6_q, b6_q;                // stage 6
    logic [DW-1:0]        r_out_q, g_out_q, b_out_q;       // stage 7

    // ---------------- control registers ----------------
    logic                 vs_act_prev_q;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic [DW-1:0]        frame_mean_q;
    logic signed [DW:0]   cur_offset_q;
    logic                 stats_valid_q;
    mode_e                mode_q;

    // ---------------- forward conversion ----------------
    logic signed [PW-1:0] r_x, g_x, b_x;
    assign r_x = PW'(vid.r_in);
    assign g_x = PW'(vid.g_in);
    assign b_x = PW'(vid.b_in);

    // ---------------- adjust ----------------
    logic signed [DW:0]   off_eff;
    logic signed [DW+1:0] ysum_adj;
    logic [DW-1:0]        y_adj;
    assign off_eff  = (mode_q == MODE_MAN || mode_q == MODE_AUTO) ? cur_offset_q : '0;
    assign ysum_adj = $signed({2'b00, y_q}) + $signed({off_eff[DW], off_eff});
    // Bit DW+1 = negative, bit DW = above full scale.
    assign y_adj    = ysum_adj[DW+1] ? '0 : (ysum_adj[DW] ? '1 : ysum_adj[DW-1:0]);

    // ---------------- inverse conversion ----------------
    logic signed [DW:0]   du_s, dv_s;
    logic signed [PW-1:0] du_x, dv_x, yc_x;
    assign du_s = $signed({1'b0, ua_q}) - $signed({1'b0, H});
    assign dv_s = $signed({1'b0, va_q}) - $signed({1'b0, H});
    assign du_x = PW'(du_s);
    assign dv_x = PW'(dv_s);
    assign yc_x = PW'(yc_q);

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            sync_q  <= '0;
            y_sum_q <= '0; u_sum_q <= '0; v_sum_q <= '0;
            y_q     <= '0; u_q     <= '0; v_q     <= '0;
            ya_q    <= '0; ua_q    <= '0; va_q    <= '0;
            yb_q    <= '0; pr_q    <= '0; pg_q    <= '0; pb_q <= '0;
            yc_q    <= '0; rt_q    <= '0; gt_q    <= '0; bt_q <= '0;
            r6_q    <= '0; g6_q    <= '0; b6_q    <= '0;
            r_out_q <= '0; g_out_q <= '0; b_out_q <= '0;
        end else begin
            sync_q  <= {sync_q[3*LAT-4:0], vid.vs_in, vid.hs_in, vid.de_in};
            y_sum_q <= K77 * r_x + K150 * g_x + K29 * b_x;
            u_sum_q <= K128 * b_x - K43 * r_x - K85 * g_x;
            v_sum_q <= K128 * r_x - K107 * g_x - K21 * b_x;
            // Chroma results always land in [0, 2^DW-1], so the add wraps cleanly.
            y_q     <= DW'(y_sum_q >>> 8);
            u_q     <= DW'(u_sum_q >>> 8) + H;
            v_q     <= DW'(v_sum_q >>> 8) + H;
            ya_q    <= y_adj;
            ua_q    <= u_q;
            va_q    <= v_q;
            yb_q    <= ya_q;
            pr_q    <= K359 * dv_x;
            pg_q    <= K88 * du_x + K183 * dv_x;
            pb_q    <= K454 * du_x;
            yc_q    <= yb_q;
            rt_q    <= pr_q >>> 8;
            gt_q    <= pg_q >>> 8;
            bt_q    <= pb_q >>> 8;
            r6_q    <= clamp_pw(yc_x + rt_q);
            g6_q    <= clamp_pw(yc_x - gt_q);
            b6_q    <= clamp_pw(yc_x + bt_q);
            // DE of the stage feeding the output register blanks the pixel.
            r_out_q <= sync_q[3*(LAT-2)] ? r6_q : '0;
            g_out_q <= sync_q[3*(LAT-2)] ? g6_q : '0;
            b_out_q <= sync_q[3*(LAT-2)] ? b6_q : '0;
        end
    end

    // ---------------- statistics and offset control ----------------
    logic                 vs_act, boundary, de_y, full;
    logic [DW-1:0]        mean_new;
    logic signed [EW-1:0] cur_x, err, step_s, d, nsum;
    logic signed [DW:0]   auto_off;

    assign vs_act   = (vid.vs_in == VS_POL[0]);
    assign boundary = vs_act && !vs_act_prev_q;
    assign de_y     = sync_q[3];               // DE aligned with y_q
    assign full     = cnt_q[SAMPLE_LOG];
    assign mean_new = acc_q[AW-1:SAMPLE_LOG];

    // Step the offset toward the value that puts the corrected mean
    // (pre-adjust mean + offset) on target, by at most auto_step per frame.
    always_comb begin
        cur_x    = $signed({{2{cur_offset_q[DW]}}, cur_offset_q});
        err      = $signed({3'b000, auto_target}) - $signed({3'b000, mean_new}) - cur_x;
        step_s   = $signed({3'b000, auto_step});
        d        = err;
        if (err > step_s)
            d = step_s;
        else if (err < -step_s)
            d = -step_s;
        nsum     = cur_x + d;
        auto_off = (DW+1)'(nsum);
        if (nsum > LIM)
            auto_off = (DW+1)'(LIM);
        else if (nsum < -LIM)
            auto_off = (DW+1)'(-LIM);
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            vs_act_prev_q <= 1'b1;   // no boundary until vs has been seen inactive
            acc_q         <= '0;
            cnt_q         <= '0;
            frame_mean_q  <= '0;
            cur_offset_q  <= '0;
            stats_valid_q <= 1'b0;
            mode_q        <= MODE_BYP;
        end else begin
            vs_act_prev_q <= vs_act;
            if (boundary) begin
                if (full)
                    frame_mean_q <= mean_new;
                stats_valid_q <= full;
                acc_q         <= de_y ? AW'(y_q) : '0;
                cnt_q         <= {{(CW-1){1'b0}}, de_y};
                mode_q        <= mode_e'(mode);
                case (mode_e'(mode))
                    MODE_MAN:  cur_offset_q <= manual_offset;
                    MODE_AUTO: if (full) cur_offset_q <= auto_off;
                    default:   cur_offset_q <= '0;
                endcase
            end else if (de_y && !full) begin
                acc_q <= acc_q + AW'(y_q);
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign vid.vs_out  = sync_q[3*LAT-1];
    assign vid.hs_out  = sync_q[3*LAT-2];
    assign vid.de_out  = sync_q[3*LAT-3];
    assign vid.r_out   = r_out_q;
    assign vid.g_out   = g_out_q;
    assign vid.b_out   = b_out_q;
    assign frame_mean  = frame_mean_q;
    assign cur_offset  = cur_offset_q;
    assign stats_valid = stats_valid_q;
endmodule
